// File: rtl/legv8_pkg.sv
// Shared FSM states, opcode patterns and datapath control encodings
// for the LEGv8 multi-cycle controller.
package legv8_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE     = 4'd0;
    localparam state_t S_FETCH    = 4'd1;
    localparam state_t S_DECODE   = 4'd2;
    localparam state_t S_MEM_ADDR = 4'd3;
    localparam state_t S_MEM_RD   = 4'd4;
    localparam state_t S_MEM_WB   = 4'd5;
    localparam state_t S_MEM_WR   = 4'd6;
    localparam state_t S_R_EXEC   = 4'd7;
    localparam state_t S_R_WB     = 4'd8;
    localparam state_t S_BRANCH   = 4'd9;
    localparam state_t S_JUMP     = 4'd10;
    localparam state_t S_TRAP     = 4'd11;

    // R-type pattern 1x_x01_01x_000
    localparam logic [10:0] OP_R_MASK   = 11'b10011110111;
    localparam logic [10:0] OP_R_PAT    = 11'b10001010000;
    localparam logic [10:0] OP_LDUR_PAT = 11'b11111000010;
    localparam logic [10:0] OP_STUR_PAT = 11'b11111000000;
    localparam logic [10:0] OP_CBZ_MASK = 11'b11111111000;
    localparam logic [10:0] OP_CBZ_PAT  = 11'b10110100000;
    localparam logic [10:0] OP_B_MASK   = 11'b11111100000;
    localparam logic [10:0] OP_B_PAT    = 11'b00010100000;

    localparam logic [1:0] ALUB_REG     = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_PASSB = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef struct packed {
        logic is_r;
        logic is_ldur;
        logic is_stur;
        logic is_cbz;
        logic is_b;
        logic illegal;
    } opclass_t;

    function automatic logic op_match(
        input logic [10:0] op,
        input logic [10:0] mask,
        input logic [10:0] pat
    );
        return (op & mask) == pat;
    endfunction

endpackage

// File: rtl/legv8_opdecode.sv
// Combinational LEGv8 opcode classifier.
// B is only recognised when LEGV8_B_INSN_EN is defined.
module legv8_opdecode
    import legv8_pkg::*;
(
    input  logic [10:0] opcode_i,
    output opclass_t    class_o
);

    always_comb begin
        class_o         = '0;
        class_o.is_r    = op_match(opcode_i, OP_R_MASK, OP_R_PAT);
        class_o.is_ldur = (opcode_i == OP_LDUR_PAT);
        class_o.is_stur = (opcode_i == OP_STUR_PAT);
        class_o.is_cbz  = op_match(opcode_i, OP_CBZ_MASK, OP_CBZ_PAT);
`ifdef LEGV8_B_INSN_EN
        class_o.is_b    = op_match(opcode_i, OP_B_MASK, OP_B_PAT);
`else
        class_o.is_b    = 1'b0;
`endif
        class_o.illegal = !(class_o.is_r | class_o.is_ldur |
                            class_o.is_stur | class_o.is_cbz |
                            class_o.is_b);
    end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// LEGv8 multi-cycle sequencer with memory handshake and trap handling.
// Optional B instruction support via LEGV8_B_INSN_EN.
module legv8_multicycle_ctrl
    import legv8_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [10:0] opcode,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        pc_source,
    output logic        ir_write,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        reg2loc,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        retire,
    output logic        illegal,
    output logic        mem_err
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             mem_err_q, mem_err_d;
    logic             wait_st;
    logic             next_fetch;
    opclass_t         cls;

    legv8_opdecode u_opdecode (
        .opcode_i (opcode),
        .class_o  (cls)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign wait_st = (state_q == S_FETCH) ||
                     (state_q == S_MEM_RD) ||
                     (state_q == S_MEM_WR);
    assign next_fetch = run;

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        illegal_d = illegal_q;
        mem_err_d = mem_err_q;
        case (state_q)
            S_IDLE:     if (run) state_d = S_FETCH;
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    cls.is_r:    state_d = S_R_EXEC;
                    cls.is_ldur: state_d = S_MEM_ADDR;
                    cls.is_stur: state_d = S_MEM_ADDR;
                    cls.is_cbz:  state_d = S_BRANCH;
                    cls.is_b:    state_d = S_JUMP;
                    default:     state_d = S_TRAP;
                endcase
                illegal_d = illegal_q | cls.illegal;
            end
            S_MEM_ADDR: state_d = cls.is_stur ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WR: begin
                if (mem_ready)
                    state_d = next_fetch ? S_FETCH : S_IDLE;
            end
            S_R_EXEC:   state_d = S_R_WB;
            S_R_WB, S_MEM_WB, S_BRANCH, S_JUMP:
                state_d = next_fetch ? S_FETCH : S_IDLE;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
        // A ready on the last allowed cycle completes normally.
        if (wait_st && !mem_ready) begin
            if (cnt_q == TMO_LAST) begin
                state_d   = S_TRAP;
                mem_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        reg2loc       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUB_REG;
        alu_op        = ALU_ADD;
        retire        = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ALUB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = ALUB_IMM_SH2;
                reg2loc   = cls.is_stur | cls.is_cbz;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
                reg2loc   = cls.is_stur;
            end
            S_MEM_RD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            S_MEM_WR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                reg2loc   = 1'b1;
                retire    = mem_ready;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                reg2loc       = 1'b1;
                alu_src_a     = 1'b1;
                alu_op        = ALU_PASSB;
                pc_write_cond = 1'b1;
                pc_source     = 1'b1;
                retire        = 1'b1;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 1'b1;
                retire    = 1'b1;
            end
            default: ;
        endcase
    end

    assign illegal = illegal_q;
    assign mem_err = mem_err_q;

endmodule
